// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction and a data requester,
// data-first with a starvation bound and speculative instruction refetch.
package mem_arbiter_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;
  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;
  state_t r_state, w_next;
  logic r_ipv, r_dpv, r_issue, r_stale;
  logic [SW-1:0] r_starve;
  mem_in_type r_ireq, r_dreq, r_req, w_ireq, w_dreq;
  logic w_inew, w_dacc, w_ip, w_dp, w_gi, w_gd, w_done, w_iresp, w_dresp;
  // A strobe seen at the granting edge counts as pending, giving 1-cycle issue latency
  always_comb begin
    w_inew = imem_in.mem_valid;
    w_ireq = w_inew ? imem_in : r_ireq;
    w_ip = r_ipv | w_inew;
    w_done = (r_state != IDLE) & mem_out.mem_ready;
    w_dacc = dmem_in.mem_valid & ~r_dpv & ((r_state != DBUSY) | mem_out.mem_ready);
    w_dreq = w_dacc ? dmem_in : r_dreq;
    w_dp = r_dpv | w_dacc;
    w_gi = (r_state == IDLE) & w_ip & (~w_dp | (r_starve == LIM));
    w_gd = (r_state == IDLE) & w_dp & ~w_gi;
    w_next = w_gi ? IBUSY : w_gd ? DBUSY : w_done ? IDLE : r_state;
    w_iresp = (r_state == IBUSY) & mem_out.mem_ready & ~r_stale;
    w_dresp = (r_state == DBUSY) & mem_out.mem_ready;
    imem_out = '{mem_ready: w_iresp, mem_rdata: w_iresp ? mem_out.mem_rdata : 32'd0};
    dmem_out = '{mem_ready: w_dresp, mem_rdata: w_dresp ? mem_out.mem_rdata : 32'd0};
    mem_in = r_req;
    mem_in.mem_valid = r_issue;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ipv <= 1'b0;
      r_dpv <= 1'b0;
      r_issue <= 1'b0;
      r_stale <= 1'b0;
      r_starve <= '0;
      r_ireq <= '0;
      r_dreq <= '0;
      r_req <= '0;
    end else begin
      r_ipv <= w_ip & ~w_gi;
      r_dpv <= w_dp & ~w_gd;
      r_ireq <= w_ireq;
      r_dreq <= w_dreq;
      r_req <= w_gi ? w_ireq : w_gd ? w_dreq : r_req;
      r_issue <= w_gi | w_gd;
      r_stale <= w_done ? 1'b0 : ((r_state == IBUSY) & w_inew & imem_in.mem_spec) ? 1'b1 : r_stale;
      r_starve <= w_gi ? '0 : (w_gd & w_ip & (r_starve != LIM)) ? r_starve + 1'b1 : r_starve;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter issue order, responses,
// starvation bound, speculative refetch and asynchronous reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mem_in_type imem_in, dmem_in, mem_in;
  mem_out_type imem_out, dmem_out, mem_out;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int resp_cnt = 0, n_dresp = 0, base = 0;
  int t_strobe = 0, t_iiss = 0, t_dresp = 0;
  logic [31:0] resp_addr = 32'd0;
  bit resp_en = 1'b1;
  logic [68:0] q_iss[$];
  logic [31:0] q_i[$], q_d[$];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clk), .reset(rst_n),
    .imem_in(imem_in), .imem_out(imem_out),
    .dmem_in(dmem_in), .dmem_out(dmem_out),
    .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // memory model: answers each issued request 2 cycles later
  initial forever begin
    @(posedge clk);
    #1;
    if (resp_en) begin
      mem_out = '0;
      if (resp_cnt == 1) mem_out = '{1'b1, rd(resp_addr)};
      if (resp_cnt > 0) resp_cnt--;
      if (mem_in.mem_valid) begin
        resp_cnt = 2;
        resp_addr = mem_in.mem_addr;
      end
    end
  end

  always @(negedge clk) begin
    logic [68:0] e;
    if (mem_in.mem_valid) begin
      if (q_iss.size() != 0) begin
        e = q_iss.pop_front();
        check("iss_addr", mem_in.mem_addr, e[67:36]);
        check("iss_attr", {27'd0, mem_in.mem_instr, mem_in.mem_wstrb}, {27'd0, e[68], e[3:0]});
        check("iss_wdata", mem_in.mem_wdata, e[35:4]);
      end else check("iss_unexpected", mem_in.mem_addr, 32'hFFFFFFFF);
      if (mem_in.mem_instr) t_iiss = cyc;
    end
    if (imem_out.mem_ready) begin
      if (q_i.size() != 0) check("iresp", imem_out.mem_rdata, q_i.pop_front());
      else check("iresp_unexpected", 32'(imem_out.mem_ready), 32'd0);
    end
    if (dmem_out.mem_ready) begin
      n_dresp++;
      t_dresp = cyc;
      if (q_d.size() != 0) check("dresp", dmem_out.mem_rdata, q_d.pop_front());
      else check("dresp_unexpected", 32'(dmem_out.mem_ready), 32'd0);
    end
  end

  task automatic pulse(input bit iv, input bit sp, input logic [31:0] ia,
                       input bit dv, input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws);
    @(posedge clk);
    #1;
    imem_in = '{iv, 1'b0, sp, 1'b1, ia, 32'd0, 4'd0};
    dmem_in = '{dv, 1'b0, 1'b0, 1'b0, da, wd, ws};
    t_strobe = cyc;
    @(posedge clk);
    #1;
    imem_in.mem_valid = 1'b0;
    dmem_in.mem_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (q_iss.size() == 0) && (q_i.size() == 0) && (q_d.size() == 0) && (resp_cnt == 0);
    end
    check("drain", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(mem_in.mem_valid), 32'd0);
    check("rst_addr", mem_in.mem_addr, 32'd0);
    check("rst_iready", 32'(imem_out.mem_ready), 32'd0);
    check("rst_dready", 32'(dmem_out.mem_ready), 32'd0);
    rst_n = 1'b1;
    // single instruction fetch
    q_iss.push_back({1'b1, 32'h100, 32'd0, 4'd0});
    q_i.push_back(32'hDEADBEEF);
    pulse(1'b1, 1'b0, 32'h100, 1'b0, 32'd0, 32'd0, 4'd0);
    drain();
    check("lat_issue", 32'(t_iiss - t_strobe), 32'd1);
    check("iout_idle", imem_out.mem_rdata, 32'd0);
    // simultaneous requests: data first, instruction after a 1-cycle gap
    q_iss.push_back({1'b0, 32'h8000, 32'd0, 4'd0});
    q_iss.push_back({1'b1, 32'h200, 32'd0, 4'd0});
    q_d.push_back(rd(32'h8000));
    q_i.push_back(rd(32'h200));
    pulse(1'b1, 1'b0, 32'h200, 1'b1, 32'h8000, 32'd0, 4'd0);
    drain();
    check("gap", 32'(t_iiss - t_dresp), 32'd2);
    // speculative refetch while the first fetch is in flight
    q_iss.push_back({1'b1, 32'h300, 32'd0, 4'd0});
    q_iss.push_back({1'b1, 32'h400, 32'd0, 4'd0});
    q_i.push_back(rd(32'h400));
    pulse(1'b1, 1'b0, 32'h300, 1'b0, 32'd0, 32'd0, 4'd0);
    pulse(1'b1, 1'b1, 32'h400, 1'b0, 32'd0, 32'd0, 4'd0);
    drain();
    // write pass-through
    q_iss.push_back({1'b0, 32'h10, 32'h12345678, 4'hF});
    q_d.push_back(rd(32'h10));
    pulse(1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 32'h12345678, 4'hF);
    drain();
    // starvation: data strobing continuously with an instruction waiting
    for (int i = 0; i < 4; i++) q_iss.push_back({1'b0, 32'h9000, 32'd0, 4'd0});
    q_iss.push_back({1'b1, 32'h500, 32'd0, 4'd0});
    q_iss.push_back({1'b0, 32'h9000, 32'd0, 4'd0});
    for (int i = 0; i < 5; i++) q_d.push_back(rd(32'h9000));
    q_i.push_back(rd(32'h500));
    base = n_dresp;
    @(posedge clk);
    #1;
    imem_in = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 32'd0, 4'd0};
    dmem_in = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h9000, 32'd0, 4'd0};
    @(posedge clk);
    #1;
    imem_in.mem_valid = 1'b0;
    for (int i = 0; i < 200 && n_dresp < base + 4; i++) @(negedge clk);
    @(posedge clk);
    #1;
    dmem_in.mem_valid = 1'b0;
    drain();
    check("starve_clr", 32'(dut.r_starve), 32'd0);
    // asynchronous reset in the middle of a data transaction
    resp_en = 1'b0;
    q_iss.push_back({1'b0, 32'h20, 32'd0, 4'd0});
    pulse(1'b0, 1'b0, 32'd0, 1'b1, 32'h20, 32'd0, 4'd0);
    @(negedge clk);
    #1;
    mem_out = '{1'b1, 32'hCAFEF00D};
    #1;
    check("fwd_pre_rst", dmem_out.mem_rdata, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    check("rst_async_dready", 32'(dmem_out.mem_ready), 32'd0);
    check("rst_async_drdata", dmem_out.mem_rdata, 32'd0);
    check("rst_async_addr", mem_in.mem_addr, 32'd0);
    mem_out = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_out = '{1'b1, 32'hCAFEF00D};
    @(negedge clk);
    check("late_ready", 32'(dmem_out.mem_ready), 32'd0);
    @(posedge clk);
    #1;
    mem_out = '0;
    resp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("queues_empty", 32'(q_iss.size() + q_i.size() + q_d.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
